// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage sitting right after execute. Issues loads and
// stores on a ready/valid data bus, aligns store byte lanes, extracts and
// sign/zero-extends load data, and registers the selected result for
// writeback. Upstream is stalled while a bus access is outstanding; an
// access that never sees mem_ready is abandoned after TIMEOUT wait cycles.
//
// State table:
//   IDLE | no access outstanding; a new access issues here, zero-wait
//        | completions also finish here
//   WAIT | access issued, waiting for mem_ready; counter tracks wait cycles
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   alu_res             address for accesses, otherwise writeback data
//   store_data          rs2 value for stores
//   pc_plus_4           link value for JAL/JALR
//   dr_num, reg_write   destination register and its write enable
//   result_src          00/11 ALU, 01 load data, 10 pc_plus_4
//   mem_write, mem_read store / load instruction (both set = store)
//   funct3              access size and signedness
//   mem_req .. mem_be   data-bus request side
//   mem_rdata, mem_ready data-bus response side
//   stall               freezes upstream stages and PC
//   misalign            one-cycle pulse, misaligned access dropped
//   bus_timeout         one-cycle pulse, access abandoned
//   wb_*                registered writeback fields
//   fwd_data            combinational stage result for forwarding
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_res,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_plus_4,
  input  logic [4:0]  dr_num,
  input  logic [1:0]  result_src,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        reg_write,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        misalign,
  output logic        bus_timeout,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dr_num,
  output logic        wb_reg_write,
  output logic [31:0] fwd_data
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        access;
  logic        is_b;
  logic        is_h;
  logic        aligned;
  logic        misaligned;
  logic        go;
  logic        at_limit;
  logic        timeout_now;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  logic [31:0] ld_data;

  // Size decode: anything that is not B/BU or H/HU is handled as a word.
  assign access     = mem_read | mem_write;
  assign is_b       = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign is_h       = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign aligned    = is_b ? 1'b1 :
                      is_h ? ~alu_res[0] :
                             (alu_res[1:0] == 2'b00);
  assign misaligned = access & ~aligned;
  assign go         = access & aligned;

  // Last permitted wait cycle; a ready here still completes the access.
  assign at_limit    = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));
  assign timeout_now = go & at_limit & ~mem_ready;

  // Combinational so upstream advances in the same cycle the bus completes.
  assign mem_req = ~reset & go & ~timeout_now;
  assign stall   = ~reset & go & ~mem_ready & ~at_limit;

  // Store lane placement.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    if (is_b) begin
      st_be    = 4'b0001 << alu_res[1:0];
      st_wdata = {4{store_data[7:0]}};
    end else if (is_h) begin
      st_be    = alu_res[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{store_data[15:0]}};
    end
  end

  // A request with both read and write set goes out as a store.
  assign mem_we    = mem_req & mem_write;
  assign mem_be    = mem_write ? st_be : 4'b0000;
  assign mem_addr  = {alu_res[31:2], 2'b00};
  assign mem_wdata = st_wdata;

  // Load lane extraction and extension.
  always_comb begin
    case (alu_res[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half   = alu_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_signed = ~funct3[2];
    if (is_b)
      ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
    else if (is_h)
      ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
    else
      ld_data = mem_rdata;
  end

  always_comb begin
    case (result_src)
      2'b01:   fwd_data = ld_data;
      2'b10:   fwd_data = pc_plus_4;
      default: fwd_data = alu_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wb_result    <= '0;
      wb_dr_num    <= '0;
      wb_reg_write <= 1'b0;
      misalign     <= 1'b0;
      bus_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go && !mem_ready) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          // Leaving on !go only guards against an upstream that ignored stall.
          if (!go || mem_ready || at_limit) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      misalign    <= misaligned;
      bus_timeout <= timeout_now;

      if (stall) begin
        wb_reg_write <= 1'b0;
      end else begin
        wb_result    <= fwd_data;
        wb_dr_num    <= dr_num;
        wb_reg_write <= reg_write & ~misaligned & ~timeout_now;
      end
    end
  end

endmodule
